// File: rtl/mac_col_feeder_if.sv
// Source-vector handshake between the vector supplier and the column feeder.
// master drives valid/data, slave (feeder) returns ready.
interface mac_col_feeder_if #(
  parameter int bw = 8,
  parameter int pr = 8
);
  logic              src_valid;
  logic [pr*bw-1:0]  src_data;
  logic              src_ready;

  modport master (
    output src_valid,
    output src_data,
    input  src_ready
  );

  modport slave (
    input  src_valid,
    input  src_data,
    output src_ready
  );
endinterface

// File: rtl/mac_col_feeder.sv
// Column-0 feeder for a chain of MAC columns: loads col+2 key vectors,
// then streams n_query queries. Optional macro: FEEDER_STALL_CNT_EN.
module mac_col_feeder #(
  parameter int bw  = 8,
  parameter int pr  = 8,
  parameter int col = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [7:0]        n_query,
  mac_col_feeder_if.slave   src,
  input  logic              load_ready_in,
  output logic [pr*bw-1:0]  q_out,
  output logic [1:0]        o_inst,
  output logic              busy,
  output logic              done,
  output logic [15:0]       stall_cnt
);

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    GAP,
    EXEC,
    DRAIN
  } state_t;

  // Key beats per job; the drain also lasts this many cycles.
  localparam logic [7:0] LOAD_N = 8'(col + 2);

  state_t            state_q, state_d;
  logic [7:0]        cnt_q, cnt_d;
  logic [7:0]        nq_q, nq_d;
  logic [pr*bw-1:0]  q_out_q, q_out_d;
  logic [1:0]        o_inst_q, o_inst_d;
  logic              done_q, done_d;
  logic              ready_c;
  logic              beat_c;
  logic              accept_c;

  // Ready only while the current phase still expects beats.
  always_comb begin
    ready_c = 1'b0;
    if (state_q == LOAD)
      ready_c = (cnt_q < LOAD_N);
    else if (state_q == EXEC)
      ready_c = (cnt_q < nq_q);
  end

  assign src.src_ready = ready_c;
  assign beat_c   = src.src_valid & ready_c;
  assign accept_c = (state_q == IDLE) & start & load_ready_in;

  // Next-state, beat counter and registered column outputs.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    nq_d     = nq_q;
    q_out_d  = q_out_q;
    o_inst_d = 2'b00;
    done_d   = 1'b0;
    if (beat_c) begin
      q_out_d  = src.src_data;
      o_inst_d = (state_q == LOAD) ? 2'b01 : 2'b10;
    end
    unique case (state_q)
      IDLE: begin
        if (accept_c) begin
          state_d = LOAD;
          cnt_d   = 8'd0;
          nq_d    = n_query;
        end
      end
      LOAD: begin
        if (beat_c) begin
          if (cnt_q == LOAD_N - 8'd1) begin
            state_d = GAP;
            cnt_d   = 8'd0;
          end else begin
            cnt_d = cnt_q + 8'd1;
          end
        end
      end
      GAP: begin
        state_d = (nq_q == 8'd0) ? DRAIN : EXEC;
        cnt_d   = 8'd0;
      end
      EXEC: begin
        if (beat_c) begin
          if (cnt_q == nq_q - 8'd1) begin
            state_d = DRAIN;
            cnt_d   = 8'd0;
          end else begin
            cnt_d = cnt_q + 8'd1;
          end
        end
      end
      DRAIN: begin
        if (cnt_q == LOAD_N - 8'd1) begin
          state_d = IDLE;
          cnt_d   = 8'd0;
          done_d  = 1'b1;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = 8'd0;
      end
    endcase
  end

  // State and output registers, synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= IDLE;
      cnt_q    <= 8'd0;
      nq_q     <= 8'd0;
      q_out_q  <= '0;
      o_inst_q <= 2'b00;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      nq_q     <= nq_d;
      q_out_q  <= q_out_d;
      o_inst_q <= o_inst_d;
      done_q   <= done_d;
    end
  end

  assign q_out  = q_out_q;
  assign o_inst = o_inst_q;
  assign done   = done_q;
  assign busy   = (state_q != IDLE);

`ifdef FEEDER_STALL_CNT_EN
  logic [15:0] stall_q, stall_d;

  // Count starved cycles, saturating; a new job restarts the count.
  always_comb begin
    stall_d = stall_q;
    if (accept_c)
      stall_d = 16'd0;
    else if (ready_c && !src.src_valid && stall_q != 16'hFFFF)
      stall_d = stall_q + 16'd1;
  end

  // Stall counter register.
  always_ff @(posedge clk) begin
    if (reset)
      stall_q <= 16'd0;
    else
      stall_q <= stall_d;
  end

  assign stall_cnt = stall_q;
`else
  assign stall_cnt = 16'd0;
`endif

endmodule

// File: tb/tb_mac_col_feeder.sv
// Directed bench for mac_col_feeder (col=8): timing, data order,
// starvation, n_query=0, ignored starts and mid-job reset.
module tb_mac_col_feeder;
  localparam int BW  = 8;
  localparam int PR  = 8;
  localparam int COL = 8;
`ifdef FEEDER_STALL_CNT_EN
  localparam int STALL_EXP = 10;
`else
  localparam int STALL_EXP = 0;
`endif

  logic             clk = 1'b0;
  logic             reset = 1'b1;
  logic             start = 1'b0;
  logic [7:0]       n_query = 8'd0;
  logic             load_ready_in = 1'b0;
  logic [PR*BW-1:0] q_out;
  logic [1:0]       o_inst;
  logic             busy;
  logic             done;
  logic [15:0]      stall_cnt;
  int               total = 0;
  int               bad = 0;

  mac_col_feeder_if #(.bw(BW), .pr(PR)) sif ();

  mac_col_feeder #(.bw(BW), .pr(PR), .col(COL)) dut (
    .clk           (clk),
    .reset         (reset),
    .start         (start),
    .n_query       (n_query),
    .src           (sif),
    .load_ready_in (load_ready_in),
    .q_out         (q_out),
    .o_inst        (o_inst),
    .busy          (busy),
    .done          (done),
    .stall_cnt     (stall_cnt)
  );

  always #5 clk = ~clk;

  function automatic logic [PR*BW-1:0] vec(input int i);
    logic [PR*BW-1:0] v;
    for (int k = 0; k < PR; k++) v[k*BW +: BW] = BW'(i * 16 + k + 1);
    return v;
  endfunction

  task automatic test_reset();
    sif.src_valid = 1'b0;
    sif.src_data  = '0;
    reset = 1'b1;
    repeat (2) @(negedge clk);
    total++;
    if (q_out !== '0) begin
      bad++; $display("FAIL rst_q got=%h exp=0", q_out);
    end
    total++;
    if (o_inst !== 2'b00) begin
      bad++; $display("FAIL rst_oinst got=%b exp=00", o_inst);
    end
    total++;
    if (busy !== 1'b0) begin
      bad++; $display("FAIL rst_busy got=%b exp=0", busy);
    end
    total++;
    if (done !== 1'b0) begin
      bad++; $display("FAIL rst_done got=%b exp=0", done);
    end
    total++;
    if (stall_cnt !== 16'd0) begin
      bad++; $display("FAIL rst_stall got=%0d exp=0", stall_cnt);
    end
    total++;
    if (sif.src_ready !== 1'b0) begin
      bad++; $display("FAIL rst_ready got=%b exp=0", sif.src_ready);
    end
    reset = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_full_job();
    int idx;
    logic [1:0] ei;
    logic eb, ed, er;
    logic [PR*BW-1:0] eq;
    idx = 0;
    n_query = 8'd4; load_ready_in = 1'b1; start = 1'b1;
    sif.src_valid = 1'b1; sif.src_data = vec(0);
    @(negedge clk);
    start = 1'b0;
    for (int c = 1; c <= 27; c++) begin
      ei = (c >= 2 && c <= 11) ? 2'b01 :
           (c >= 13 && c <= 16) ? 2'b10 : 2'b00;
      eb = (c <= 25);
      ed = (c == 26);
      er = (c <= 10) || (c >= 12 && c <= 15);
      total++;
      if (o_inst !== ei) begin
        bad++; $display("FAIL full_oinst c=%0d got=%b exp=%b", c, o_inst, ei);
      end
      total++;
      if (busy !== eb) begin
        bad++; $display("FAIL full_busy c=%0d got=%b exp=%b", c, busy, eb);
      end
      total++;
      if (done !== ed) begin
        bad++; $display("FAIL full_done c=%0d got=%b exp=%b", c, done, ed);
      end
      total++;
      if (sif.src_ready !== er) begin
        bad++;
        $display("FAIL full_ready c=%0d got=%b exp=%b", c, sif.src_ready, er);
      end
      if (c >= 2 && c <= 16) begin
        eq = (c <= 11) ? vec(c - 2) : (c == 12) ? vec(9) : vec(c - 3);
        total++;
        if (q_out !== eq) begin
          bad++; $display("FAIL full_data c=%0d got=%h exp=%h", c, q_out, eq);
        end
      end
      sif.src_data = vec(idx);
      if (sif.src_ready && sif.src_valid) idx++;
      @(negedge clk);
    end
  endtask

  task automatic test_stall();
    int idx, nl;
    logic [1:0] ei;
    idx = 0; nl = 0;
    n_query = 8'd1; start = 1'b1;
    sif.src_valid = 1'b0; sif.src_data = vec(0);
    @(negedge clk);
    start = 1'b0;
    for (int c = 1; c <= 34; c++) begin
      if (o_inst === 2'b01) nl++;
      if (c >= 2 && c <= 21) begin
        ei = (c % 2 == 1) ? 2'b01 : 2'b00;
        total++;
        if (o_inst !== ei) begin
          bad++;
          $display("FAIL stall_oinst c=%0d got=%b exp=%b", c, o_inst, ei);
        end
      end
      if (c == 23) begin
        total++;
        if (o_inst !== 2'b10) begin
          bad++; $display("FAIL stall_exec got=%b exp=10", o_inst);
        end
      end
      if (c == 33) begin
        total++;
        if (done !== 1'b1) begin
          bad++; $display("FAIL stall_done got=%b exp=1", done);
        end
      end
      sif.src_valid = (c <= 20) ? (c % 2 == 0) : 1'b1;
      sif.src_data = vec(idx);
      if (sif.src_ready && sif.src_valid) idx++;
      @(negedge clk);
    end
    total++;
    if (nl !== 10) begin
      bad++; $display("FAIL stall_loads got=%0d exp=10", nl);
    end
    total++;
    if (stall_cnt !== 16'(STALL_EXP)) begin
      bad++; $display("FAIL stall_cnt got=%0d exp=%0d", stall_cnt, STALL_EXP);
    end
  endtask

  task automatic test_zero_query();
    logic eb, ed;
    n_query = 8'd0; start = 1'b1;
    sif.src_valid = 1'b1; sif.src_data = vec(0);
    @(negedge clk);
    start = 1'b0;
    for (int c = 1; c <= 24; c++) begin
      if (c == 1) begin
        total++;
        if (stall_cnt !== 16'd0) begin
          bad++; $display("FAIL zq_stallclr got=%0d exp=0", stall_cnt);
        end
      end
      total++;
      if (o_inst === 2'b10) begin
        bad++; $display("FAIL zq_exec c=%0d got=%b exp=not10", c, o_inst);
      end
      ed = (c == 22);
      eb = (c <= 21);
      total++;
      if (done !== ed) begin
        bad++; $display("FAIL zq_done c=%0d got=%b exp=%b", c, done, ed);
      end
      total++;
      if (busy !== eb) begin
        bad++; $display("FAIL zq_busy c=%0d got=%b exp=%b", c, busy, eb);
      end
      sif.src_data = vec(c);
      @(negedge clk);
    end
  endtask

  task automatic test_ignored_start();
    int nx;
    logic ed;
    nx = 0;
    load_ready_in = 1'b0; n_query = 8'd3; start = 1'b1;
    sif.src_valid = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int c = 0; c < 5; c++) begin
      total++;
      if (busy !== 1'b0) begin
        bad++; $display("FAIL nlr_busy c=%0d got=%b exp=0", c, busy);
      end
      total++;
      if (sif.src_ready !== 1'b0) begin
        bad++; $display("FAIL nlr_ready c=%0d got=%b exp=0", c, sif.src_ready);
      end
      @(negedge clk);
    end
    load_ready_in = 1'b1; n_query = 8'd2; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int c = 1; c <= 26; c++) begin
      if (o_inst === 2'b10) nx++;
      ed = (c == 24);
      total++;
      if (done !== ed) begin
        bad++; $display("FAIL busy_start_done c=%0d got=%b exp=%b", c, done, ed);
      end
      start = (c == 3);
      n_query = (c == 3) ? 8'd200 : 8'd2;
      sif.src_data = vec(c);
      @(negedge clk);
    end
    start = 1'b0;
    total++;
    if (nx !== 2) begin
      bad++; $display("FAIL busy_start_exec got=%0d exp=2", nx);
    end
  endtask

  task automatic test_reset_mid();
    int idx;
    logic [1:0] ei;
    logic ed;
    idx = 0;
    n_query = 8'd4; start = 1'b1;
    sif.src_valid = 1'b1; sif.src_data = vec(0);
    @(negedge clk);
    start = 1'b0;
    for (int c = 1; c <= 13; c++) begin
      sif.src_data = vec(idx);
      if (sif.src_ready && sif.src_valid) idx++;
      if (c == 13) reset = 1'b1;
      @(negedge clk);
    end
    total++;
    if (o_inst !== 2'b00) begin
      bad++; $display("FAIL rmid_oinst got=%b exp=00", o_inst);
    end
    total++;
    if (busy !== 1'b0) begin
      bad++; $display("FAIL rmid_busy got=%b exp=0", busy);
    end
    total++;
    if (sif.src_ready !== 1'b0) begin
      bad++; $display("FAIL rmid_ready got=%b exp=0", sif.src_ready);
    end
    reset = 1'b0;
    for (int c = 0; c < 15; c++) begin
      total++;
      if (done !== 1'b0) begin
        bad++; $display("FAIL rmid_done c=%0d got=%b exp=0", c, done);
      end
      @(negedge clk);
    end
    idx = 0;
    n_query = 8'd3; start = 1'b1; sif.src_data = vec(0);
    @(negedge clk);
    start = 1'b0;
    for (int c = 1; c <= 26; c++) begin
      ei = (c >= 2 && c <= 11) ? 2'b01 :
           (c >= 13 && c <= 15) ? 2'b10 : 2'b00;
      ed = (c == 25);
      total++;
      if (o_inst !== ei) begin
        bad++; $display("FAIL rerun_oinst c=%0d got=%b exp=%b", c, o_inst, ei);
      end
      total++;
      if (done !== ed) begin
        bad++; $display("FAIL rerun_done c=%0d got=%b exp=%b", c, done, ed);
      end
      if (c == 16) begin
        total++;
        if (q_out !== vec(12)) begin
          bad++; $display("FAIL rerun_data got=%h exp=%h", q_out, vec(12));
        end
      end
      sif.src_data = vec(idx);
      if (sif.src_ready && sif.src_valid) idx++;
      @(negedge clk);
    end
  endtask

  initial begin
    test_reset();
    test_full_job();
    test_stall();
    test_zero_query();
    test_ignored_start();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/mac_col_feeder.md
MAC_COL_FEEDER -- requirements
Module: mac_col_feeder

Interface
REQ-001 SHALL have parameter bw, default 8, bits per vector element.
REQ-002 SHALL have parameter pr, default 8, elements per vector.
REQ-003 SHALL have parameter col, default 8, number of chained MAC columns driven.
REQ-004 SHALL have port clk  input  1  clock, rising-edge.
REQ-005 SHALL have port reset  input  1  reset, synchronous, active-high.
REQ-006 SHALL have port start  input  1  single-cycle job request.
REQ-007 SHALL have port n_query  input  8  query vector count, sampled on accepted start.
REQ-008 SHALL have port src_valid  input  1  source vector available.
REQ-009 SHALL have port src_data  input  pr*bw  source vector (keys first, then queries).
REQ-010 SHALL have port src_ready  output  1  feeder consumes src_data this cycle.
REQ-011 SHALL have port load_ready_in  input  1  column-0 load_ready.
REQ-012 SHALL have port q_out  output  pr*bw  vector to column-0 q_in.
REQ-013 SHALL have port o_inst  output  2  to column-0 i_inst; [1] execute, [0] load.
REQ-014 SHALL have port busy  output  1  high when state is not IDLE.
REQ-015 SHALL have port done  output  1  one-cycle job-complete pulse.
REQ-016 SHALL have port stall_cnt  output  16  source-starvation cycle count.

Function
REQ-017 SHALL implement FSM states IDLE, LOAD, GAP, EXEC, DRAIN.
REQ-018 IDLE->LOAD SHALL occur when start=1 and load_ready_in=1; n_query is latched and the beat counter is cleared at that edge.
REQ-019 start in IDLE with load_ready_in=0, or start in any non-IDLE state, SHALL be ignored (not queued).
REQ-020 src_ready SHALL be combinational: 1 in LOAD or EXEC while beats remain, else 0.
REQ-021 A beat SHALL be a cycle with src_valid & src_ready; at the following edge q_out<=src_data and o_inst<=01 (LOAD) or 10 (EXEC); latency 1 cycle.
REQ-022 A non-beat cycle SHALL register o_inst<=00 at the next edge, with q_out holding its value (bubble).
REQ-023 LOAD SHALL accept exactly col+2 beats, then go to GAP.
REQ-024 GAP SHALL last exactly 1 cycle with o_inst=00, then go to EXEC, or to DRAIN if latched n_query=0.
REQ-025 EXEC SHALL accept exactly latched n_query beats, then go to DRAIN.
REQ-026 DRAIN SHALL last exactly col+2 cycles with o_inst=00, then go to IDLE with done=1 for the first IDLE cycle.
REQ-027 o_inst SHALL never equal 11.
REQ-028 Beat counters SHALL be 8 bits wide and SHALL never wrap within a job.

Reset
REQ-029 On reset, state SHALL be IDLE and o_inst, q_out, done, busy, stall_cnt and all counters SHALL be 0.
REQ-030 Reset mid-job SHALL abort the job without asserting done; src_ready SHALL be 0 in the cycle after reset.

Configuration
REQ-031 Macro FEEDER_STALL_CNT_EN defined: stall_cnt SHALL increment once per LOAD/EXEC cycle with src_ready=1 and src_valid=0, SHALL saturate at 16'hFFFF, and SHALL clear on accepted start.
REQ-032 Macro FEEDER_STALL_CNT_EN undefined: stall_cnt SHALL be constant 0 and no counter logic SHALL be built.

Verification
REQ-033 col=8, n_query=4, src_valid always 1: 10 cycles o_inst=01, 1 cycle 00, 4 cycles 10, 10 cycles 00, then done=1 for 1 cycle; busy spans exactly 25 cycles.
REQ-034 src_valid low on every other LOAD cycle: o_inst alternates 01/00, exactly 10 load beats; stall_cnt=10 with macro defined, 0 without.
REQ-035 n_query=0: GAP goes directly to DRAIN; o_inst never 10; done fires after 10 DRAIN cycles.
REQ-036 start with load_ready_in=0: busy stays 0 and src_ready stays 0; a start issued later while busy is ignored.
REQ-037 reset asserted during EXEC beat 2: next cycle o_inst=00, busy=0, src_ready=0, done never pulses; a fresh start then runs a full job correctly.
REQ-038 Data check: key vectors K0..K9 then queries Q0..Q3 appear on q_out in order, each exactly one cycle after its accept.
